output_layer_accum: RTL

Output-layer accumulator of the classifier datapath, directly upstream of the argmax stage. Streams one hidden-layer activation per beat together with its ten signed weights (one per class), and multiply-accumulates into ten signed class scores preloaded with per-class biases. When all inputs are consumed it presents the ten scores as a packed bus with a valid flag. The argmax stage consumes that bus unchanged.

---
 rtl/output_layer_accum.sv | 116 +++++++++++
 1 files changed

// File: rtl/output_layer_accum.sv
// Output-layer multiply-accumulate: ten bias-preloaded signed class scores, one
// activation per beat, saturating accumulation, scores held with NumValid in DONE.
module output_layer_accum #(
  parameter int NUM_SIZE   = 26,
  parameter int IN_WIDTH   = 8,
  parameter int W_WIDTH    = 8,
  parameter int NUM_INPUTS = 100
) (
  input  logic                     Clk,
  input  logic                     GlobalReset,
  input  logic                     Start,
  input  logic [NUM_SIZE*10-1:0]   Bias,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [IN_WIDTH-1:0]      InData,
  input  logic [W_WIDTH*10-1:0]    InWeights,
  output logic [NUM_SIZE*10-1:0]   Num,
  output logic                     NumValid,
  output logic                     Busy
);

  localparam int NC = 10;
  localparam int PW = IN_WIDTH + W_WIDTH;
  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_INPUTS - 1);
  localparam logic signed [NUM_SIZE-1:0] SCORE_MAX = {1'b0, {(NUM_SIZE-1){1'b1}}};
  localparam logic signed [NUM_SIZE-1:0] SCORE_MIN = {1'b1, {(NUM_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic signed [PW-1:0]        prod_q [NC];
  logic signed [PW-1:0]        prod_d [NC];
  logic                        prod_vld_q, prod_vld_d;
  logic signed [NUM_SIZE-1:0]  acc_q [NC];
  logic signed [NUM_SIZE-1:0]  acc_d [NC];
  logic                        beat, start_load, last_beat;

  function automatic logic signed [NUM_SIZE-1:0] sat_add(
    input logic signed [NUM_SIZE-1:0] a,
    input logic signed [PW-1:0]       p
  );
    logic signed [NUM_SIZE:0] sum;
    sum = (NUM_SIZE+1)'(a) + (NUM_SIZE+1)'(p);
    if (sum[NUM_SIZE] != sum[NUM_SIZE-1]) return sum[NUM_SIZE] ? SCORE_MIN : SCORE_MAX;
    return sum[NUM_SIZE-1:0];
  endfunction

  assign beat       = InValid && InReady;
  assign start_load = Start && (state_q == IDLE || state_q == DONE);
  assign last_beat  = beat && (cnt_q == LAST_BEAT);

  always_ff @(posedge Clk) begin
    if (GlobalReset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_load) state_d = ACCUM;
      ACCUM:   if (last_beat)  state_d = DRAIN;
      // The last product is consumed on the edge after it is registered.
      DRAIN:   if (!prod_vld_q) state_d = DONE;
      DONE:    if (start_load) state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    InReady  = (state_q == ACCUM);
    Busy     = (state_q == ACCUM) || (state_q == DRAIN);
    NumValid = (state_q == DONE);
  end

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    cnt_d      = cnt_q;
    prod_vld_d = beat;
    if (start_load) cnt_d = '0;
    else if (beat)  cnt_d = cnt_q + CW'(1);
    for (int j = 0; j < NC; j++) begin
      prod_d[j] = prod_q[j];
      acc_d[j]  = acc_q[j];
      if (beat)
        prod_d[j] = PW'($signed(InData)) * PW'($signed(InWeights[W_WIDTH*j +: W_WIDTH]));
      if (start_load)
        acc_d[j] = Bias[NUM_SIZE*j +: NUM_SIZE];
      else if (prod_vld_q)
        acc_d[j] = sat_add(acc_q[j], prod_q[j]);
    end
  end

  always_ff @(posedge Clk) begin
    if (GlobalReset) begin
      cnt_q      <= '0;
      prod_vld_q <= 1'b0;
      for (int j = 0; j < NC; j++) acc_q[j] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      prod_vld_q <= prod_vld_d;
      for (int j = 0; j < NC; j++) acc_q[j] <= acc_d[j];
    end
  end

  // NOTE: the product stage is left unreset; prod_vld_q alone decides whether it is used.
  always_ff @(posedge Clk) begin
    for (int j = 0; j < NC; j++) prod_q[j] <= prod_d[j];
  end

  for (genvar j = 0; j < NC; j++) begin : g_pack
    assign Num[NUM_SIZE*j +: NUM_SIZE] = acc_q[j];
  end

endmodule
